axicb_mst_switch_rd: RTL and testbench

Slave-side read switch of the crossbar: one instance sits in front of each slave port and accepts AR requests from up to four master-side switches. It arbitrates AR among masters round-robin, keeping the grant stable until the handshake completes, and routes R completions back to the owning master by decoding RID. It caps outstanding reads per master and tracks them with per-master counters.

---
 rtl/axicb_mst_switch_rd_if.sv | 33 +++
 rtl/axicb_mst_switch_rd.sv | 170 +++++++++++++++++
 tb/tb_axicb_mst_switch_rd.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_mst_switch_rd_if.sv
// Read-path bundle between up to four master-side switches and one slave port.
// The slave modport is the switch's view; the master modport is the surrounding fabric's view.
interface axicb_mst_switch_rd_if #(
   parameter int unsigned MST_NB = 4,
   parameter int unsigned ARCH_W = 8,
   parameter int unsigned RCH_W  = 8
);
   logic [MST_NB-1:0]        i_arvalid;
   logic [MST_NB-1:0]        i_arready;
   logic [MST_NB*ARCH_W-1:0] i_arch;
   logic [MST_NB-1:0]        i_rvalid;
   logic [MST_NB-1:0]        i_rready;
   logic [MST_NB-1:0]        i_rlast;
   logic [RCH_W-1:0]         i_rch;
   logic                     o_arvalid;
   logic                     o_arready;
   logic [ARCH_W-1:0]        o_arch;
   logic                     o_rvalid;
   logic                     o_rready;
   logic                     o_rlast;
   logic [RCH_W-1:0]         o_rch;
   logic                     o_rid_err;

   modport slave (
      input  i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
      output i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready, o_rid_err
   );

   modport master (
      output i_arvalid, i_arch, i_rready, o_arready, o_rvalid, o_rlast, o_rch,
      input  i_arready, i_rvalid, i_rlast, i_rch, o_arvalid, o_arch, o_rready, o_rid_err
   );
endinterface

// File: rtl/axicb_mst_switch_rd.sv
// Slave-side read switch: round-robin AR arbitration over up to four masters with
// per-master outstanding-read caps, and RID-decoded routing of R beats back to the owner.
module axicb_mst_switch_rd #(
   parameter int unsigned         AXI_ADDR_W      = 8,
   parameter int unsigned         AXI_ID_W        = 8,
   parameter int unsigned         MST_NB          = 4,
   parameter int unsigned         MST_OSTDREQ_NUM = 4,
   parameter logic [AXI_ID_W-1:0] MST0_ID_MASK    = AXI_ID_W'('h10),
   parameter logic [AXI_ID_W-1:0] MST1_ID_MASK    = AXI_ID_W'('h20),
   parameter logic [AXI_ID_W-1:0] MST2_ID_MASK    = AXI_ID_W'('h40),
   parameter logic [AXI_ID_W-1:0] MST3_ID_MASK    = AXI_ID_W'('h80),
   parameter int unsigned         ARCH_W          = 8,
   parameter int unsigned         RCH_W           = 8
) (
   input  logic                 aclk,
   input  logic                 srst,
   axicb_mst_switch_rd_if.slave bus
);

   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0]    OSTD_MAX = CNT_W'(MST_OSTDREQ_NUM);
   localparam logic [AXI_ID_W-1:0] ID_MASK [4] = '{MST0_ID_MASK, MST1_ID_MASK,
                                                   MST2_ID_MASK, MST3_ID_MASK};

   if (MST_NB < 1 || MST_NB > 4 || AXI_ADDR_W > ARCH_W || AXI_ID_W > RCH_W) begin : g_cfg_err
      $error("axicb_mst_switch_rd: unsupported parameter set");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]   ostd_q [MST_NB];
   logic               rid_err_q;

   logic [MST_NB-1:0]  eligible;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_hit;
   logic [IDX_W-1:0]   gnt;
   logic               arvalid_c;
   logic               ar_hs;
   logic [MST_NB-1:0]  arready_c;
   logic [AXI_ID_W-1:0] rid;
   logic [MST_NB-1:0]  sel;
   logic               r_match;
   logic               rready_c;
   logic               r_hs;
   logic [MST_NB-1:0]  ostd_inc;
   logic [MST_NB-1:0]  ostd_dec;

   // A master is only considered while it has room for another outstanding read
   always_comb begin
      eligible = '0;
      for (int m = 0; m < MST_NB; m++) begin
         eligible[m] = bus.i_arvalid[m] && (ostd_q[m] < OSTD_MAX);
      end
   end

   // Round-robin pick: first eligible master at or after ptr, circularly
   always_comb begin
      arb_idx = ptr_q;
      arb_hit = 1'b0;
      rr_idx  = '0;
      for (int i = 0; i < MST_NB; i++) begin
         rr_idx = IDX_W'((32'(ptr_q) + 32'(i)) % MST_NB);
         if (!arb_hit && eligible[rr_idx]) begin
            arb_idx = rr_idx;
            arb_hit = 1'b1;
         end
      end
   end

   // Arbiter FSM: once o_arvalid is shown without ready, the grant is frozen
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gnt       = arb_idx;
      arvalid_c = arb_hit;
      case (state_q)
         IDLE: begin
            if (arb_hit && !bus.o_arready) begin
               state_d = LOCKED;
               grant_d = arb_idx;
            end
         end
         LOCKED: begin
            gnt       = grant_q;
            arvalid_c = 1'b1;
            if (bus.o_arready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ar_hs = arvalid_c && bus.o_arready;

   always_comb begin
      arready_c      = '0;
      arready_c[gnt] = ar_hs;
   end

   assign bus.i_arready = arready_c;
   assign bus.o_arvalid = arvalid_c;
   assign bus.o_arch    = bus.i_arch[32'(gnt)*ARCH_W +: ARCH_W];

   // R owner decode: lowest master whose mask bits are all set in RID
   assign rid = bus.o_rch[AXI_ID_W-1:0];

   always_comb begin
      sel     = '0;
      r_match = 1'b0;
      for (int m = 0; m < MST_NB; m++) begin
         if (!r_match && ((rid & ID_MASK[m]) == ID_MASK[m])) begin
            sel[m]  = 1'b1;
            r_match = 1'b1;
         end
      end
   end

   // Unmatched beats are sunk so the slave never stalls on a stray RID
   assign rready_c      = r_match ? |(bus.i_rready & sel) : bus.o_rvalid;
   assign r_hs          = bus.o_rvalid && rready_c;
   assign bus.o_rready  = rready_c;
   assign bus.i_rvalid  = {MST_NB{bus.o_rvalid}} & sel;
   assign bus.i_rlast   = {MST_NB{bus.o_rlast}} & sel;
   assign bus.i_rch     = bus.o_rch;
   assign bus.o_rid_err = rid_err_q;

   always_comb begin
      ostd_inc = '0;
      ostd_dec = '0;
      for (int m = 0; m < MST_NB; m++) begin
         ostd_inc[m] = ar_hs && (gnt == IDX_W'(m));
         ostd_dec[m] = r_hs && bus.o_rlast && sel[m];
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         rid_err_q <= 1'b0;
         for (int m = 0; m < MST_NB; m++) begin
            ostd_q[m] <= '0;
         end
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rid_err_q <= r_hs && !r_match;
         if (ar_hs) begin
            ptr_q <= (32'(gnt) == MST_NB - 1) ? '0 : gnt + IDX_W'(1);
         end
         // Simultaneous issue and retire for one master cancel out
         for (int m = 0; m < MST_NB; m++) begin
            if (ostd_inc[m] && !ostd_dec[m] && (ostd_q[m] != '1)) begin
               ostd_q[m] <= ostd_q[m] + CNT_W'(1);
            end else if (ostd_dec[m] && !ostd_inc[m] && (ostd_q[m] != '0)) begin
               ostd_q[m] <= ostd_q[m] - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_axicb_mst_switch_rd.sv
// Directed bench for axicb_mst_switch_rd: arbitration order, grant locking,
// outstanding caps, RID routing, unmatched-RID sinking and reset recovery.
module tb_axicb_mst_switch_rd;

   logic aclk;
   logic srst;
   int   total;
   int   bad;
   int   beat;
   logic rr;

   axicb_mst_switch_rd_if #(.MST_NB(4), .ARCH_W(8), .RCH_W(8)) bus ();

   axicb_mst_switch_rd #(
      .AXI_ADDR_W(8), .AXI_ID_W(8), .MST_NB(4), .MST_OSTDREQ_NUM(4),
      .MST0_ID_MASK(8'h10), .MST1_ID_MASK(8'h20), .MST2_ID_MASK(8'h40), .MST3_ID_MASK(8'h80),
      .ARCH_W(8), .RCH_W(8)
   ) dut (
      .aclk (aclk),
      .srst (srst),
      .bus  (bus.slave)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiesce;
      bus.i_arvalid = '0;
      bus.i_rready  = '0;
      bus.o_arready = 1'b0;
      bus.o_rvalid  = 1'b0;
      bus.o_rlast   = 1'b0;
      bus.o_rch     = '0;
   endtask

   task automatic do_reset;
      quiesce();
      srst = 1'b1;
      tick();
      tick();
      srst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.i_arch = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      do_reset();

      // Reset state
      settle();
      chk("rst_arvalid", 32'(bus.o_arvalid), 32'd0);
      chk("rst_arready", 32'(bus.i_arready), 32'd0);
      chk("rst_rvalid",  32'(bus.i_rvalid),  32'd0);
      chk("rst_rready",  32'(bus.o_rready),  32'd0);
      chk("rst_rid_err", 32'(bus.o_rid_err), 32'd0);

      // Masters 0 and 2 compete with slave always ready: 0,2,0,2
      bus.i_arvalid = 4'b0101;
      bus.o_arready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("rr_arch",    32'(bus.o_arch),    (k % 2 == 0) ? 32'hA0 : 32'hA2);
         chk("rr_arready", 32'(bus.i_arready), (k % 2 == 0) ? 32'b0001 : 32'b0100);
         tick();
      end
      do_reset();

      // Master 1 locked through 3 stall cycles while master 0 joins
      bus.i_arvalid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) bus.i_arvalid = 4'b0011;
         bus.o_arready = (k == 3);
         settle();
         chk("lock_arvalid", 32'(bus.o_arvalid), 32'd1);
         chk("lock_arch",    32'(bus.o_arch),    32'hA1);
         chk("lock_arready", 32'(bus.i_arready), (k == 3) ? 32'b0010 : 32'b0000);
         tick();
      end
      bus.i_arvalid = 4'b0001;
      bus.o_arready = 1'b1;
      settle();
      chk("lock_next_arch",    32'(bus.o_arch),    32'hA0);
      chk("lock_next_arready", 32'(bus.i_arready), 32'b0001);
      tick();
      bus.i_arvalid = '0;

      // Master 3 fills its 4 slots, 5th request blocked
      bus.i_arvalid = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("cap_fill", 32'(bus.i_arready), 32'b1000);
         tick();
      end
      settle();
      chk("cap_blocked_rdy", 32'(bus.i_arready), 32'd0);
      chk("cap_blocked_vld", 32'(bus.o_arvalid), 32'd0);
      bus.o_rch     = 8'h85;
      bus.o_rvalid  = 1'b1;
      bus.o_rlast   = 1'b1;
      bus.i_rready  = 4'b1000;
      settle();
      chk("cap_r_rvalid", 32'(bus.i_rvalid), 32'b1000);
      chk("cap_r_rlast",  32'(bus.i_rlast),  32'b1000);
      chk("cap_r_rready", 32'(bus.o_rready), 32'd1);
      chk("cap_r_arready", 32'(bus.i_arready), 32'd0);
      tick();
      bus.o_rvalid = 1'b0;
      bus.o_rlast  = 1'b0;
      bus.i_rready = '0;
      settle();
      chk("cap_regrant", 32'(bus.i_arready), 32'b1000);
      chk("cap_regrant_arch", 32'(bus.o_arch), 32'hA3);
      tick();
      bus.i_arvalid = '0;

      // Master 1 (one outstanding) filled to its cap, then retired by a 4-beat burst
      bus.i_arvalid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("burst_fill", 32'(bus.i_arready), 32'b0010);
         tick();
      end
      bus.o_rch    = 8'h25;
      bus.o_rvalid = 1'b1;
      beat = 0;
      for (int cyc = 0; cyc < 7; cyc++) begin
         rr = (cyc % 2 == 0);
         bus.i_rready = {2'b00, rr, 1'b0};
         bus.o_rlast  = (beat == 3);
         settle();
         chk("burst_rvalid",  32'(bus.i_rvalid),  32'b0010);
         chk("burst_rready",  32'(bus.o_rready),  32'(rr));
         chk("burst_rlast",   32'(bus.i_rlast),   (beat == 3) ? 32'b0010 : 32'b0000);
         chk("burst_rch",     32'(bus.i_rch),     32'h25);
         chk("burst_blocked", 32'(bus.i_arready), 32'd0);
         tick();
         if (rr) beat++;
      end
      bus.o_rvalid = 1'b0;
      bus.o_rlast  = 1'b0;
      bus.i_rready = '0;
      settle();
      chk("burst_release", 32'(bus.i_arready), 32'b0010);
      tick();
      bus.i_arvalid = '0;

      // Unmatched RID: beats sunk, error pulses, master 3 still at its cap
      bus.o_rch     = 8'h05;
      bus.o_rvalid  = 1'b1;
      bus.o_rlast   = 1'b1;
      bus.i_arvalid = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("err_rready",  32'(bus.o_rready),  32'd1);
         chk("err_rvalid",  32'(bus.i_rvalid),  32'd0);
         chk("err_pulse",   32'(bus.o_rid_err), (k > 0) ? 32'd1 : 32'd0);
         chk("err_arready", 32'(bus.i_arready), 32'd0);
         tick();
      end
      bus.o_rvalid = 1'b0;
      bus.o_rlast  = 1'b0;
      bus.i_arvalid = '0;
      settle();
      chk("err_last_pulse", 32'(bus.o_rid_err), 32'd1);
      chk("err_rready_idle", 32'(bus.o_rready), 32'd0);
      tick();
      chk("err_clear", 32'(bus.o_rid_err), 32'd0);

      // Reset while master 0 has 3 outstanding and a locked grant
      do_reset();
      bus.i_arvalid = 4'b0001;
      bus.o_arready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("srst_fill", 32'(bus.i_arready), 32'b0001);
         tick();
      end
      bus.o_arready = 1'b0;
      settle();
      chk("srst_pre_lock", 32'(bus.o_arvalid), 32'd1);
      tick();
      quiesce();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      settle();
      chk("srst_arvalid", 32'(bus.o_arvalid), 32'd0);
      chk("srst_arready", 32'(bus.i_arready), 32'd0);
      chk("srst_rready",  32'(bus.o_rready),  32'd0);
      chk("srst_rvalid",  32'(bus.i_rvalid),  32'd0);
      chk("srst_rid_err", 32'(bus.o_rid_err), 32'd0);
      bus.i_arvalid = 4'b0001;
      bus.o_arready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("srst_refill", 32'(bus.i_arready), (k < 4) ? 32'b0001 : 32'b0000);
         tick();
      end
      quiesce();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
